// File: rtl/scanram_pkg.sv
// Shared scan-RAM widths and arbiter state encoding; also used by the scan converter.
package scanram_pkg;
    localparam int unsigned SCAN_ADDR_W = 17;
    localparam int unsigned SCAN_DATA_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } scan_state_t;
endpackage

// File: rtl/scanram_wr_arbiter_if.sv
// Requester-side and scan-RAM write-port signals of the scan-RAM write arbiter.
interface scanram_wr_arbiter_if;
    import scanram_pkg::*;

    logic                   vid_we;
    logic [SCAN_ADDR_W-1:0] vid_addr;
    logic [SCAN_DATA_W-1:0] vid_data;
    logic                   osd_req;
    logic [SCAN_ADDR_W-1:0] osd_addr;
    logic [SCAN_DATA_W-1:0] osd_data;
    logic                   osd_ack;
    logic                   clear_req;
    logic                   busy;
    logic                   clear_done;
    logic                   ram_we;
    logic [SCAN_ADDR_W-1:0] ram_addr;
    logic [SCAN_DATA_W-1:0] ram_data;

    modport master (
        output vid_we, vid_addr, vid_data,
        output osd_req, osd_addr, osd_data, clear_req,
        input  osd_ack, busy, clear_done,
        input  ram_we, ram_addr, ram_data
    );

    modport slave (
        input  vid_we, vid_addr, vid_data,
        input  osd_req, osd_addr, osd_data, clear_req,
        output osd_ack, busy, clear_done,
        output ram_we, ram_addr, ram_data
    );
endinterface

// File: rtl/scanram_clear_ctr.sv
// Clear-sweep address counter: load-zero, count enable, saturates at LAST.
module scanram_clear_ctr
    import scanram_pkg::*;
#(
    parameter logic [SCAN_ADDR_W-1:0] LAST = '1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_load_zero,
    input  logic                   i_en,
    output logic [SCAN_ADDR_W-1:0] o_addr,
    output logic                   o_last
);
    logic [SCAN_ADDR_W-1:0] r_addr;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_load_zero) begin
            r_addr <= '0;
        end else if (i_en && !o_last) begin
            r_addr <= r_addr + SCAN_ADDR_W'(1);
        end
    end

    assign o_addr = r_addr;
    assign o_last = (r_addr == LAST);
endmodule

// File: rtl/scanram_wr_arbiter.sv
// Scan-RAM write arbiter: video > clear sweep > overlay, registered RAM port.
// Clear engine present only when SCANRAM_CLEAR_EN is defined.
module scanram_wr_arbiter
    import scanram_pkg::*;
#(
    parameter logic [SCAN_ADDR_W-1:0] CLEAR_LAST = 17'h1FFFF,
    parameter logic [SCAN_DATA_W-1:0] CLEAR_DATA = 8'h00
) (
    input  logic                 clk6m,
    input  logic                 reset,
    scanram_wr_arbiter_if.slave  wr
);
    logic                   w_idle;
    logic                   w_sweep;
    logic                   w_busy;
    logic                   w_done_nxt;
    logic                   w_osd_win;
    logic [SCAN_ADDR_W-1:0] w_sweep_addr;

    logic                   r_ram_we;
    logic [SCAN_ADDR_W-1:0] r_ram_addr;
    logic [SCAN_DATA_W-1:0] r_ram_data;
    logic                   r_osd_ack;
    logic                   r_clear_done;

`ifdef SCANRAM_CLEAR_EN
    scan_state_t            r_state;
    scan_state_t            w_state_nxt;
    logic                   w_load_zero;
    logic                   w_clr_last;

    scanram_clear_ctr #(
        .LAST (CLEAR_LAST)
    ) u_clear_ctr (
        .i_clk       (clk6m),
        .i_rst       (reset),
        .i_load_zero (w_load_zero),
        .i_en        (w_sweep),
        .o_addr      (w_sweep_addr),
        .o_last      (w_clr_last)
    );

    always_ff @(posedge clk6m) begin
        if (reset) begin
            r_state <= CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A clear_req cycle issues no sweep write; the sweep restarts at 0 next cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_load_zero = wr.clear_req;
        w_sweep     = 1'b0;
        case (r_state)
            IDLE: begin
                if (wr.clear_req) begin
                    w_state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                if (!wr.clear_req && !wr.vid_we) begin
                    w_sweep = 1'b1;
                    if (w_clr_last) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_idle     = (r_state == IDLE);
    assign w_busy     = (r_state == CLEAR);
    assign w_done_nxt = w_sweep & w_clr_last;
`else
    logic w_unused_cfg;

    assign w_idle       = 1'b1;
    assign w_sweep      = 1'b0;
    assign w_busy       = 1'b0;
    assign w_done_nxt   = 1'b0;
    assign w_sweep_addr = '0;
    assign w_unused_cfg = ^{wr.clear_req, CLEAR_LAST};
`endif

    assign w_osd_win = w_idle & ~wr.vid_we & wr.osd_req;

    always_ff @(posedge clk6m) begin
        if (reset) begin
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_data   <= '0;
            r_osd_ack    <= 1'b0;
            r_clear_done <= 1'b0;
        end else begin
            r_ram_we     <= wr.vid_we | w_sweep | w_osd_win;
            r_osd_ack    <= w_osd_win;
            r_clear_done <= w_done_nxt;
            if (wr.vid_we) begin
                r_ram_addr <= wr.vid_addr;
                r_ram_data <= wr.vid_data;
            end else if (w_sweep) begin
                r_ram_addr <= w_sweep_addr;
                r_ram_data <= CLEAR_DATA;
            end else if (w_osd_win) begin
                r_ram_addr <= wr.osd_addr;
                r_ram_data <= wr.osd_data;
            end
        end
    end

    assign wr.ram_we     = r_ram_we;
    assign wr.ram_addr   = r_ram_addr;
    assign wr.ram_data   = r_ram_data;
    assign wr.osd_ack    = r_osd_ack;
    assign wr.clear_done = r_clear_done;
    assign wr.busy       = w_busy;
endmodule

// File: tb/tb_scanram_wr_arbiter.sv
// Directed bench for scanram_wr_arbiter; covers the clear engine when SCANRAM_CLEAR_EN is defined.
module tb_scanram_wr_arbiter;
    logic        clk;
    logic        rst;
    int unsigned n_checks;
    int unsigned n_errors;

    scanram_wr_arbiter_if wr();

    scanram_wr_arbiter #(
        .CLEAR_LAST (17'h000FF),
        .CLEAR_DATA (8'h00)
    ) dut (
        .clk6m (clk),
        .reset (rst),
        .wr    (wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_port(input string tag, input logic we, input logic [16:0] addr,
                            input logic [7:0] data, input logic ack, input logic done,
                            input logic busy);
        chk({tag, " ram_we"},     32'(wr.ram_we),     32'(we));
        chk({tag, " ram_addr"},   32'(wr.ram_addr),   32'(addr));
        chk({tag, " ram_data"},   32'(wr.ram_data),   32'(data));
        chk({tag, " osd_ack"},    32'(wr.osd_ack),    32'(ack));
        chk({tag, " clear_done"}, 32'(wr.clear_done), 32'(done));
        chk({tag, " busy"},       32'(wr.busy),       32'(busy));
    endtask

    task automatic idle_inputs();
        wr.vid_we    = 1'b0;
        wr.vid_addr  = '0;
        wr.vid_data  = '0;
        wr.osd_req   = 1'b0;
        wr.osd_addr  = '0;
        wr.osd_data  = '0;
        wr.clear_req = 1'b0;
    endtask

    task automatic common_tests();
        idle_inputs();
        wr.vid_we = 1'b1; wr.vid_addr = 17'h00123; wr.vid_data = 8'h5A;
        step(); chk_port("vid", 1'b1, 17'h00123, 8'h5A, 1'b0, 1'b0, 1'b0);
        wr.vid_we = 1'b0;
        step(); chk_port("hold", 1'b0, 17'h00123, 8'h5A, 1'b0, 1'b0, 1'b0);
        // overlay request stalled three cycles behind video
        wr.osd_req = 1'b1; wr.osd_addr = 17'h01234; wr.osd_data = 8'hA5;
        for (int unsigned k = 0; k < 3; k++) begin
            wr.vid_we = 1'b1; wr.vid_addr = 17'h00200 + 17'(k); wr.vid_data = 8'h10 + 8'(k);
            step(); chk_port("osd_wait", 1'b1, 17'h00200 + 17'(k), 8'h10 + 8'(k), 1'b0, 1'b0, 1'b0);
        end
        wr.vid_we = 1'b0;
        step(); chk_port("osd_grant", 1'b1, 17'h01234, 8'hA5, 1'b1, 1'b0, 1'b0);
        wr.osd_addr = 17'h1FFFE; wr.osd_data = 8'h3C;
        step(); chk_port("osd_b2b", 1'b1, 17'h1FFFE, 8'h3C, 1'b1, 1'b0, 1'b0);
        wr.osd_req = 1'b0;
        step(); chk_port("osd_drop", 1'b0, 17'h1FFFE, 8'h3C, 1'b0, 1'b0, 1'b0);
    endtask

`ifdef SCANRAM_CLEAR_EN
    task automatic sweep(input int unsigned from, input int unsigned to, input bit brk);
        for (int unsigned a = from; a <= to; a++) begin
            if (brk && a == 32'h40) begin
                for (int unsigned k = 0; k < 10; k++) begin
                    wr.vid_we = 1'b1; wr.vid_addr = 17'h18000 + 17'(k); wr.vid_data = 8'hC0 + 8'(k);
                    step(); chk_port("sweep_vid", 1'b1, 17'h18000 + 17'(k), 8'hC0 + 8'(k), 1'b0, 1'b0, 1'b1);
                end
                wr.vid_we = 1'b0;
            end
            step();
            chk_port("sweep", 1'b1, 17'(a), 8'h00, 1'b0, (a == 32'hFF), (a != 32'hFF));
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle_inputs();
        rst = 1'b1;
        wr.vid_we = 1'b1; wr.vid_addr = 17'h00055; wr.vid_data = 8'h66;
`ifdef SCANRAM_CLEAR_EN
        step(); chk_port("reset", 1'b0, 17'h0, 8'h0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        idle_inputs();
        sweep(0, 255, 1'b1);
        step(); chk_port("post_sweep", 1'b0, 17'h000FF, 8'h00, 1'b0, 1'b0, 1'b0);
        common_tests();
        // restart mid-sweep, then restart coincident with the final address
        wr.clear_req = 1'b1;
        step(); chk_port("clr_start", 1'b0, 17'h1FFFE, 8'h3C, 1'b0, 1'b0, 1'b1);
        wr.clear_req = 1'b0;
        sweep(0, 32'h7F, 1'b0);
        wr.clear_req = 1'b1;
        step(); chk_port("clr_restart", 1'b0, 17'h0007F, 8'h00, 1'b0, 1'b0, 1'b1);
        wr.clear_req = 1'b0;
        sweep(0, 32'hFE, 1'b0);
        wr.clear_req = 1'b1;
        step(); chk_port("clr_final", 1'b0, 17'h000FE, 8'h00, 1'b0, 1'b0, 1'b1);
        wr.clear_req = 1'b0;
        sweep(0, 255, 1'b0);
        step(); chk_port("post_restart", 1'b0, 17'h000FF, 8'h00, 1'b0, 1'b0, 1'b0);
        // reset mid-sweep with an overlay request pending
        wr.clear_req = 1'b1;
        step(); chk_port("clr_again", 1'b0, 17'h000FF, 8'h00, 1'b0, 1'b0, 1'b1);
        wr.clear_req = 1'b0;
        sweep(0, 32'h0F, 1'b0);
        wr.osd_req = 1'b1; wr.osd_addr = 17'h0ABCD; wr.osd_data = 8'h5E;
        rst = 1'b1;
        step(); chk_port("rst_mid", 1'b0, 17'h0, 8'h0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        sweep(0, 255, 1'b0);
        step(); chk_port("osd_after", 1'b1, 17'h0ABCD, 8'h5E, 1'b1, 1'b0, 1'b0);
        wr.osd_req = 1'b0;
        step(); chk_port("osd_after_drop", 1'b0, 17'h0ABCD, 8'h5E, 1'b0, 1'b0, 1'b0);
`else
        wr.osd_req = 1'b1; wr.clear_req = 1'b1;
        step(); chk_port("reset", 1'b0, 17'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        idle_inputs();
        common_tests();
        wr.clear_req = 1'b1;
        step(); chk_port("clr_ign", 1'b0, 17'h1FFFE, 8'h3C, 1'b0, 1'b0, 1'b0);
        wr.clear_req = 1'b0;
        for (int unsigned k = 0; k < 3; k++) begin
            step(); chk_port("clr_ign_idle", 1'b0, 17'h1FFFE, 8'h3C, 1'b0, 1'b0, 1'b0);
        end
        wr.osd_req = 1'b1; wr.osd_addr = 17'h00042; wr.osd_data = 8'h77;
        step(); chk_port("osd_1cyc", 1'b1, 17'h00042, 8'h77, 1'b1, 1'b0, 1'b0);
        wr.osd_addr = 17'h00043; wr.osd_data = 8'h88; wr.clear_req = 1'b1;
        step(); chk_port("osd_with_clr", 1'b1, 17'h00043, 8'h88, 1'b1, 1'b0, 1'b0);
        wr.clear_req = 1'b0;
        wr.osd_addr = 17'h00999; wr.osd_data = 8'h99;
        rst = 1'b1;
        step(); chk_port("rst_mid", 1'b0, 17'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        wr.osd_req = 1'b0;
        step(); chk_port("post_rst", 1'b0, 17'h0, 8'h0, 1'b0, 1'b0, 1'b0);
`endif
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
